// File: rtl/nios_mult_pkg.sv
// Shared definitions for the Nios M-stage multiply pipeline: mode encoding,
// fixed pipeline depth and the slice-count helper.
package nios_mult_pkg;

    localparam logic [1:0] MODE_MUL    = 2'd0;
    localparam logic [1:0] MODE_MULXSS = 2'd1;
    localparam logic [1:0] MODE_MULXSU = 2'd2;
    localparam logic [1:0] MODE_MULXUU = 2'd3;

    localparam int LATENCY = 3;

    function automatic int num_slices(input int data_w, input int part_w);
        return data_w / part_w;
    endfunction

endpackage

// File: rtl/nios_mult_part.sv
// Registered unsigned PART_W x PART_W partial-product cell; one DSP multiplier
// with a hold enable and an asynchronous active-high clear.
module nios_mult_part #(
    parameter int PART_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [PART_W-1:0]     a,
    input  logic [PART_W-1:0]     b,
    output logic [2*PART_W-1:0]   p
);

    logic [2*PART_W-1:0] p_d, p_q;

    // NOTE: next state gets a full default before any condition, so no latch is
    // inferred; the flop below only ever uses non-blocking assignment.
    always_comb begin
        p_d = p_q;
        if (en) begin
            p_d = (2*PART_W)'(a) * (2*PART_W)'(b);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p_q <= '0;
        end else begin
            p_q <= p_d;
        end
    end

    assign p = p_q;

endmodule

// File: rtl/nios_mult_pipe.sv
// Three-stage pipelined integer multiplier (mul/mulxss/mulxsu/mulxuu) with a
// valid/tag sideband, stall and flush, built from registered DSP slices.
module nios_mult_pipe
    import nios_mult_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int PART_W  = 16,
    parameter int TAG_W   = 5,
    parameter int LATENCY = nios_mult_pkg::LATENCY
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [1:0]        in_mode,
    input  logic [DATA_W-1:0] in_src1,
    input  logic [DATA_W-1:0] in_src2,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_result,
    output logic [TAG_W-1:0]  out_tag
);

    localparam int NS = num_slices(DATA_W, PART_W);
    localparam int PW = 2 * DATA_W;

    if (LATENCY != nios_mult_pkg::LATENCY || (DATA_W % PART_W) != 0) begin : g_bad_cfg
        $error("nios_mult_pipe: unsupported LATENCY or DATA_W not a multiple of PART_W");
    end

    logic advance;
    assign advance = ~stall;

    // S1: operands carry one extra sign bit so the slices stay unsigned.
    logic              valid1_d, valid1_q;
    logic [1:0]        mode1_d,  mode1_q;
    logic [TAG_W-1:0]  tag1_d,   tag1_q;
    logic [DATA_W:0]   a1_d,     a1_q;
    logic [DATA_W:0]   b1_d,     b1_q;

    logic              valid2_d, valid2_q;
    logic [1:0]        mode2_d,  mode2_q;
    logic [TAG_W-1:0]  tag2_d,   tag2_q;
    logic [DATA_W:0]   corr2_d,  corr2_q;
    logic [2*PART_W-1:0] part_p [NS*NS];

    logic              out_valid_d,  out_valid_q;
    logic [DATA_W-1:0] out_result_d, out_result_q;
    logic [TAG_W-1:0]  out_tag_d,    out_tag_q;
    logic [PW-1:0]     prod;

    always_comb begin
        valid1_d = valid1_q;
        mode1_d  = mode1_q;
        tag1_d   = tag1_q;
        a1_d     = a1_q;
        b1_d     = b1_q;
        if (advance) begin
            valid1_d = in_valid;
            mode1_d  = in_mode;
            tag1_d   = in_tag;
            a1_d     = {(in_mode == MODE_MULXSS || in_mode == MODE_MULXSU) & in_src1[DATA_W-1], in_src1};
            b1_d     = {(in_mode == MODE_MULXSS) & in_src2[DATA_W-1], in_src2};
        end
        if (flush) begin
            valid1_d = 1'b0;
        end
    end

    // A negative operand contributes -(other operand) << DATA_W; the sign*sign
    // term lands at 2^(2*DATA_W) and vanishes modulo the product width.
    always_comb begin
        valid2_d = valid2_q;
        mode2_d  = mode2_q;
        tag2_d   = tag2_q;
        corr2_d  = corr2_q;
        if (advance) begin
            valid2_d = valid1_q;
            mode2_d  = mode1_q;
            tag2_d   = tag1_q;
            corr2_d  = (a1_q[DATA_W] ? {1'b0, b1_q[DATA_W-1:0]} : '0)
                     + (b1_q[DATA_W] ? {1'b0, a1_q[DATA_W-1:0]} : '0);
        end
        if (flush) begin
            valid2_d = 1'b0;
        end
    end

    for (genvar i = 0; i < NS; i++) begin : g_row
        for (genvar j = 0; j < NS; j++) begin : g_col
            nios_mult_part #(.PART_W(PART_W)) u_part (
                .clk   (clk),
                .reset (reset),
                .en    (advance),
                .a     (a1_q[i*PART_W +: PART_W]),
                .b     (b1_q[j*PART_W +: PART_W]),
                .p     (part_p[i*NS+j])
            );
        end
    end

    always_comb begin
        prod = '0;
        for (int i = 0; i < NS; i++) begin
            for (int j = 0; j < NS; j++) begin
                prod = prod + (PW'(part_p[i*NS+j]) << ((i + j) * PART_W));
            end
        end
        prod = prod - (PW'(corr2_q) << DATA_W);
    end

    always_comb begin
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_tag_d    = out_tag_q;
        if (advance) begin
            out_valid_d = valid2_q;
            if (valid2_q && !flush) begin
                out_result_d = (mode2_q == MODE_MUL) ? prod[DATA_W-1:0] : prod[PW-1:DATA_W];
                out_tag_d    = tag2_q;
            end
        end
        if (flush) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid1_q     <= 1'b0;
            mode1_q      <= '0;
            tag1_q       <= '0;
            a1_q         <= '0;
            b1_q         <= '0;
            valid2_q     <= 1'b0;
            mode2_q      <= '0;
            tag2_q       <= '0;
            corr2_q      <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_tag_q    <= '0;
        end else begin
            valid1_q     <= valid1_d;
            mode1_q      <= mode1_d;
            tag1_q       <= tag1_d;
            a1_q         <= a1_d;
            b1_q         <= b1_d;
            valid2_q     <= valid2_d;
            mode2_q      <= mode2_d;
            tag2_q       <= tag2_d;
            corr2_q      <= corr2_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_tag_q    <= out_tag_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_tag    = out_tag_q;

endmodule

// File: tb/tb_nios_mult_pipe.sv
// Self-checking bench for nios_mult_pipe: directed vector table, stall/flush/
// reset sequences and a randomized run against a latency-queue reference model.
module tb_nios_mult_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        in_valid;
    logic [1:0]  in_mode;
    logic [31:0] in_src1;
    logic [31:0] in_src2;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic [31:0] out_result;
    logic [4:0]  out_tag;

    int total = 0;
    int bad   = 0;

    nios_mult_pipe #(.DATA_W(32), .PART_W(16), .TAG_W(5), .LATENCY(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_mode    (in_mode),
        .in_src1    (in_src1),
        .in_src2    (in_src2),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_result (out_result),
        .out_tag    (out_tag)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [1:0]  mode;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  tag;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
        int          left;
    } flight_t;

    vec_t        vecs[8];
    flight_t     flight[$];
    logic        m_valid;
    logic [31:0] m_res;
    logic [4:0]  m_tag;

    // Reference: exact 64-bit product of the operands interpreted per mode.
    function automatic logic [31:0] ref_result(input logic [1:0] mode, input logic [31:0] a,
                                               input logic [31:0] b);
        longint x, y, p;
        x = (mode == 2'd1 || mode == 2'd2) ? longint'($signed(a)) : longint'({32'd0, a});
        y = (mode == 2'd1) ? longint'($signed(b)) : longint'({32'd0, b});
        p = x * y;
        return (mode == 2'd0) ? p[31:0] : p[63:32];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] mode, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] tag);
        in_valid = v;
        in_mode  = mode;
        in_src1  = a;
        in_src2  = b;
        in_tag   = tag;
    endtask

    task automatic idle();
        drive(1'b0, 2'd0, 32'd0, 32'd0, 5'd0);
    endtask

    // One clock edge: the model consumes the inputs seen at the edge, then
    // outputs are sampled 1 time unit after it.
    task automatic tick();
        flight_t f;
        if (flush) begin
            flight.delete();
            m_valid = 1'b0;
        end else if (!stall) begin
            m_valid = 1'b0;
            foreach (flight[k]) flight[k].left--;
            if (flight.size() > 0 && flight[0].left == 0) begin
                f = flight.pop_front();
                m_valid = 1'b1;
                m_res   = f.res;
                m_tag   = f.tag;
            end
            if (in_valid) begin
                f.res  = ref_result(in_mode, in_src1, in_src2);
                f.tag  = in_tag;
                f.left = 2;
                flight.push_back(f);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        flight.delete();
        m_valid = 1'b0;
        m_res   = '0;
        m_tag   = '0;
    endtask

    task automatic check_out(input string name, input logic v, input logic [31:0] r,
                             input logic [4:0] t);
        check({name, ".valid"},  64'(out_valid),  64'(v));
        check({name, ".result"}, 64'(out_result), 64'(r));
        check({name, ".tag"},    64'(out_tag),    64'(t));
    endtask

    initial begin
        int issued;
        int cycles;

        vecs[0] = '{2'd0, 32'h0001_0003, 32'h0002_0005, 5'd7,  32'h000B_000F};
        vecs[1] = '{2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1,  32'hFFFF_FFFE};
        vecs[2] = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'h0000_0000};
        vecs[3] = '{2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFF};
        vecs[4] = '{2'd1, 32'h8000_0000, 32'h8000_0000, 5'd4,  32'h4000_0000};
        vecs[5] = '{2'd2, 32'h8000_0000, 32'h0000_0002, 5'd5,  32'hFFFF_FFFF};
        vecs[6] = '{2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'h0000_0001};
        vecs[7] = '{2'd1, 32'h7FFF_FFFF, 32'h8000_0000, 5'd8,  32'hC000_0000};

        reset = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        idle();
        model_clear();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check_out("reset_state", 1'b0, 32'd0, 5'd0);
        #3 reset = 1'b0;
        @(posedge clk);
        #1;

        // Single MUL: exact 3-edge latency.
        drive(1'b1, vecs[0].mode, vecs[0].a, vecs[0].b, vecs[0].tag);
        tick();
        idle();
        check("lat.edge1_valid", 64'(out_valid), 64'd0);
        tick();
        check("lat.edge2_valid", 64'(out_valid), 64'd0);
        tick();
        check_out("lat.edge3", 1'b1, vecs[0].exp, vecs[0].tag);
        tick();
        check_out("lat.bubble", 1'b0, vecs[0].exp, vecs[0].tag);

        // Table, back to back: results on consecutive cycles in issue order.
        for (int c = 0; c < 10; c++) begin
            if (c < 8) drive(1'b1, vecs[c].mode, vecs[c].a, vecs[c].b, vecs[c].tag);
            else idle();
            tick();
            if (c >= 2) check_out($sformatf("b2b[%0d]", c - 2), 1'b1, vecs[c-2].exp, vecs[c-2].tag);
        end
        idle();

        // Stall two cycles with the op in S2.
        drive(1'b1, 2'd3, 32'h1234_5678, 32'h9ABC_DEF0, 5'd9);
        tick();
        idle();
        tick();
        stall = 1'b1;
        tick();
        check_out("stall.c3", 1'b0, vecs[7].exp, vecs[7].tag);
        drive(1'b1, 2'd0, 32'h5, 32'h5, 5'd30);
        tick();
        check_out("stall.c4", 1'b0, vecs[7].exp, vecs[7].tag);
        stall = 1'b0;
        idle();
        tick();
        check_out("stall.c5", 1'b1, ref_result(2'd3, 32'h1234_5678, 32'h9ABC_DEF0), 5'd9);
        tick();
        check("stall.after_valid", 64'(out_valid), 64'd0);

        // Flush with ops in flight plus a simultaneous issue, stall also high.
        for (int c = 1; c <= 3; c++) begin
            drive(1'b1, vecs[c].mode, vecs[c].a, vecs[c].b, vecs[c].tag);
            tick();
        end
        check_out("flush.pre", 1'b1, vecs[1].exp, vecs[1].tag);
        drive(1'b1, vecs[4].mode, vecs[4].a, vecs[4].b, vecs[4].tag);
        flush = 1'b1;
        stall = 1'b1;
        tick();
        flush = 1'b0;
        stall = 1'b0;
        idle();
        check_out("flush.edge", 1'b0, vecs[1].exp, vecs[1].tag);
        for (int c = 0; c < 3; c++) begin
            tick();
            check_out($sformatf("flush.after[%0d]", c), 1'b0, vecs[1].exp, vecs[1].tag);
        end
        drive(1'b1, vecs[5].mode, vecs[5].a, vecs[5].b, vecs[5].tag);
        tick();
        idle();
        tick();
        tick();
        check_out("flush.next_op", 1'b1, vecs[5].exp, vecs[5].tag);

        // Asynchronous reset mid-cycle with ops in flight.
        drive(1'b1, vecs[1].mode, vecs[1].a, vecs[1].b, vecs[1].tag);
        tick();
        drive(1'b1, vecs[4].mode, vecs[4].a, vecs[4].b, vecs[4].tag);
        tick();
        idle();
        #2 reset = 1'b1;
        #1;
        check_out("areset.immediate", 1'b0, 32'd0, 5'd0);
        @(posedge clk);
        #1;
        check_out("areset.held", 1'b0, 32'd0, 5'd0);
        #3 reset = 1'b0;
        model_clear();
        for (int c = 0; c < 4; c++) begin
            tick();
            check_out($sformatf("areset.release[%0d]", c), 1'b0, 32'd0, 5'd0);
        end

        // Randomized run against the reference model.
        issued = 0;
        cycles = 0;
        while (issued < 10000 && cycles < 40000) begin
            stall = ($urandom_range(0, 7) == 0);
            flush = ($urandom_range(0, 63) == 0);
            drive(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), $urandom, $urandom,
                  5'($urandom_range(0, 31)));
            if (($urandom_range(0, 7)) == 0) in_src1 = {in_src1[31], 31'd0};
            if (($urandom_range(0, 7)) == 0) in_src2 = 32'hFFFF_FFFF;
            if (in_valid && !stall && !flush) issued++;
            tick();
            cycles++;
            check_out("rand", m_valid, m_res, m_tag);
        end
        check("rand.issued_all", 64'(issued), 64'd10000);
        stall = 1'b0;
        flush = 1'b0;
        idle();
        for (int c = 0; c < 4; c++) begin
            tick();
            check_out("drain", m_valid, m_res, m_tag);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
